// File: rtl/accumulate_pkg.sv
// Width helpers shared by the accumulation stage.
package accumulate_pkg;

   // Accumulator width: wide enough that N full-scale products cannot overflow.
   function automatic int acc_width(input int argw, input int n);
      return (n > 1) ? argw + $clog2(n) : argw + 1;
   endfunction

   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/saturate.sv
// Combinational signed clamp from INW bits down to OUTW bits (INW >= OUTW).
module saturate #(
   parameter int INW  = 34,
   parameter int OUTW = 16
) (
   input  logic signed [INW-1:0]  din,
   output logic signed [OUTW-1:0] dout
);

   // In range iff every bit above the output sign bit matches the input sign.
   always_comb begin
      dout = din[OUTW-1:0];
      if (din[INW-1:OUTW-1] != {(INW-OUTW+1){din[INW-1]}})
         dout = din[INW-1] ? {1'b1, {(OUTW-1){1'b0}}} : {1'b0, {(OUTW-1){1'b1}}};
   end

endmodule

// File: rtl/accumulate.sv
// Sums groups of N signed products, rescales by SHIFT and saturates into a
// registered strobe/ready result port.
module accumulate
   import accumulate_pkg::*;
#(
   parameter int ARGW  = 32,
   parameter int N     = 4,
   parameter int SHIFT = 8,
   parameter int RESW  = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            arg_stb,
   input  logic [ARGW-1:0] arg_dat,
   output logic            arg_rdy,
   output logic            res_stb,
   output logic [RESW-1:0] res_dat,
   input  logic            res_rdy
);

   localparam int ACCW = acc_width(ARGW, N);
   localparam int CNTW = cnt_width(N);

   logic signed [ACCW-1:0] acc;
   logic signed [ACCW-1:0] sum;
   logic signed [ACCW-1:0] shifted;
   logic signed [RESW-1:0] sat_out;
   logic [CNTW-1:0]        cnt;
   logic                   arg_ack;
   logic                   last;

   assign arg_rdy = ~res_stb | res_rdy;
   assign arg_ack = arg_stb & arg_rdy;
   assign last    = (cnt == CNTW'(N-1));
   assign sum     = acc + {{(ACCW-ARGW){arg_dat[ARGW-1]}}, arg_dat};
   assign shifted = sum >>> SHIFT;

   saturate #(.INW(ACCW), .OUTW(RESW)) u_sat (
      .din  (shifted),
      .dout (sat_out)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         acc     <= '0;
         cnt     <= '0;
         res_stb <= 1'b0;
         res_dat <= '0;
      end else begin
         if (res_stb && res_rdy)
            res_stb <= 1'b0;
         // A last term landing on the ack cycle reloads with no bubble.
         if (arg_ack) begin
            if (last) begin
               res_dat <= sat_out;
               res_stb <= 1'b1;
               acc     <= '0;
               cnt     <= '0;
            end else begin
               acc <= sum;
               cnt <= cnt + CNTW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_accumulate.sv
// Directed bench for accumulate (ARGW=32, N=4, SHIFT=8, RESW=16).
module tb_accumulate;

   logic        clk = 1'b0;
   logic        rst;
   logic        arg_stb;
   logic [31:0] arg_dat;
   logic        arg_rdy;
   logic        res_stb;
   logic [15:0] res_dat;
   logic        res_rdy;

   int n_cmp = 0;
   int n_err = 0;
   logic [15:0] got_q[$];
   logic [15:0] exp_q[$];

   accumulate #(.ARGW(32), .N(4), .SHIFT(8), .RESW(16)) dut (
      .clk     (clk),
      .rst     (rst),
      .arg_stb (arg_stb),
      .arg_dat (arg_dat),
      .arg_rdy (arg_rdy),
      .res_stb (res_stb),
      .res_dat (res_dat),
      .res_rdy (res_rdy)
   );

   always #5 clk = ~clk;

   // Inputs change 1 time unit after posedge, so negedge shows the coming handshake.
   always @(negedge clk)
      if (!rst && res_stb && res_rdy) got_q.push_back(res_dat);

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic group(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                        input logic [31:0] d, input logic [15:0] exp, input string tag);
      logic [31:0] t[4];
      t = '{a, b, c, d};
      res_rdy = 1'b1;
      for (int i = 0; i < 4; i++) begin
         arg_stb = 1'b1;
         arg_dat = t[i];
         step();
         if (i < 3) chk({tag, "_idle"}, 32'(res_stb), 32'd0);
      end
      arg_stb = 1'b0;
      arg_dat = 32'hDEADBEEF;
      chk({tag, "_stb"}, 32'(res_stb), 32'd1);
      chk({tag, "_dat"}, 32'(res_dat), 32'(exp));
      exp_q.push_back(exp);
      step();
      chk({tag, "_ack"}, 32'(res_stb), 32'd0);
   endtask

   initial begin
      rst = 1'b1; arg_stb = 1'b0; arg_dat = '0; res_rdy = 1'b1;
      step(); step();
      rst = 1'b0;
      chk("rst_stb", 32'(res_stb), 32'd0);
      chk("rst_dat", 32'(res_dat), 32'd0);
      chk("rst_rdy", 32'(arg_rdy), 32'd1);

      group(32'h00010000, 32'h00010000, 32'h00010000, 32'h00010000, 16'h0400, "one");
      group(32'hFFFF0000, 32'hFFFF0000, 32'hFFFF0000, 32'hFFFF0000, 16'hFC00, "neg_one");
      group(32'h7FFF0000, 32'h7FFF0000, 32'h7FFF0000, 32'h7FFF0000, 16'h7FFF, "sat_pos");
      group(32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000, 16'h8000, "sat_neg");
      group(32'hFFFFFF7F, 32'h0, 32'h0, 32'h0, 16'hFFFF, "trunc_neg");
      group(32'h00000080, 32'h00000080, 32'h00000080, 32'h00000080, 16'h0002, "trunc_pos");

      // Back-to-back groups of 1.0 at full rate.
      res_rdy = 1'b1;
      for (int i = 0; i < 12; i++) begin
         arg_stb = 1'b1;
         arg_dat = 32'h00010000;
         step();
         chk("b2b_stb", 32'(res_stb), (i % 4 == 3) ? 32'd1 : 32'd0);
         if (i % 4 == 3) begin
            chk("b2b_dat", 32'(res_dat), 32'h0400);
            exp_q.push_back(16'h0400);
         end
      end
      arg_stb = 1'b0;
      step();
      chk("b2b_end", 32'(res_stb), 32'd0);

      // Backpressure: result held while downstream stalls.
      res_rdy = 1'b0;
      for (int i = 0; i < 4; i++) begin
         arg_stb = 1'b1;
         arg_dat = 32'h00020000;
         step();
      end
      chk("bp_stb", 32'(res_stb), 32'd1);
      chk("bp_dat", 32'(res_dat), 32'h0800);
      exp_q.push_back(16'h0800);
      arg_dat = 32'h00010000;
      for (int i = 0; i < 3; i++) begin
         chk("bp_rdy", 32'(arg_rdy), 32'd0);
         step();
         chk("bp_hold_stb", 32'(res_stb), 32'd1);
         chk("bp_hold_dat", 32'(res_dat), 32'h0800);
      end
      res_rdy = 1'b1;
      #1;
      chk("bp_release_rdy", 32'(arg_rdy), 32'd1);
      step();
      chk("bp_acked", 32'(res_stb), 32'd0);
      for (int i = 0; i < 3; i++) step();
      chk("bp_next_stb", 32'(res_stb), 32'd1);
      chk("bp_next_dat", 32'(res_dat), 32'h0400);
      exp_q.push_back(16'h0400);
      arg_stb = 1'b0;
      step();
      chk("bp_next_ack", 32'(res_stb), 32'd0);

      // Reset mid-group discards the partial sum.
      for (int i = 0; i < 2; i++) begin
         arg_stb = 1'b1;
         arg_dat = 32'h7FFF0000;
         step();
      end
      arg_stb = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("midrst_stb", 32'(res_stb), 32'd0);
      chk("midrst_dat", 32'(res_dat), 32'd0);
      group(32'h00010000, 32'h00010000, 32'h00010000, 32'h00010000, 16'h0400, "after_rst");

      // Reset while a result is pending drops it.
      res_rdy = 1'b0;
      for (int i = 0; i < 4; i++) begin
         arg_stb = 1'b1;
         arg_dat = 32'h00030000;
         step();
      end
      arg_stb = 1'b0;
      chk("pend_stb", 32'(res_stb), 32'd1);
      chk("pend_dat", 32'(res_dat), 32'h0C00);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("pend_drop_stb", 32'(res_stb), 32'd0);
      chk("pend_drop_dat", 32'(res_dat), 32'd0);
      res_rdy = 1'b1;
      step(); step();

      chk("n_results", 32'(got_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         chk("result_order", 32'(got_q[i]), 32'(exp_q[i]));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
